ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the consecutive fetch-denial cycles before fetch is forced (used only with RAM_ARB_FAIR_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have fetch ports: if_req in 1 (read request); if_addr in 32; if_flush in 1 (discard outstanding fetch response); if_gnt out 1; if_rvalid out 1; if_rdata out 32.
REQ-005 SHALL have load/store ports: ls_req in 1; ls_we in 1 (1 = write); ls_wstrb in 4 (byte enables); ls_addr in 32; ls_wdata in 32; ls_gnt out 1; ls_rvalid out 1; ls_rdata out 32.
REQ-006 SHALL have single-port RAM ports: ram_en out 1; ram_we out 4; ram_addr out 32; ram_wdata out 32; ram_rdata in 32 (valid one cycle after a read enable).

Function
REQ-007 SHALL issue at most one RAM access per cycle; ram_en = if_gnt | ls_gnt.
REQ-008 SHALL compute grants combinationally in the request cycle; a request is accepted exactly when its gnt is 1 in that cycle.
REQ-009 SHALL, with no fairness feature, give ls priority: ls_gnt = ls_req; if_gnt = if_req & ~ls_req.
REQ-010 SHALL drive ram_addr/ram_wdata/ram_we from the granted port; ram_we = ls_wstrb when ls_gnt & ls_we, else 4'b0; ram_addr = 0 when idle.
REQ-011 SHALL hold a 2-bit response-owner register with states NONE, IF, LS: next = LS on ls read grant, IF on fetch grant, else NONE.
REQ-012 SHALL assert if_rvalid in the cycle after an IF grant (owner == IF) with if_rdata = ram_rdata; likewise ls_rvalid/ls_rdata for owner == LS; read latency exactly 1 cycle.
REQ-013 SHALL produce no rvalid for an ls write; owner becomes NONE.
REQ-014 SHALL suppress if_rvalid when if_flush is high in the response cycle; a fetch granted in the same cycle as if_flush is still returned next cycle (flush kills only the older response).
REQ-015 SHALL keep if_rdata/ls_rdata equal to ram_rdata unconditionally; consumers qualify with rvalid.
REQ-016 SHALL never assert if_rvalid and ls_rvalid together.
REQ-017 SHALL accept back-to-back grants every cycle with no bubble; responses are not back-pressured.

Reset
REQ-018 SHALL, while rst_n == 0, force if_gnt, ls_gnt, ram_en, ram_we to 0 combinationally.
REQ-019 SHALL, on a clock edge with rst_n == 0, set owner to NONE and starvation counter to 0; if_rvalid and ls_rvalid read 0 the following cycle.
REQ-020 SHALL drop any outstanding response when reset is applied mid-operation; no rvalid for pre-reset grants.

Configuration
REQ-021 SHALL support macro RAM_ARB_FAIR_EN; when defined, a 3-bit starvation counter increments each cycle if_req is denied by ls_req, clears on any if grant or when if_req is low, saturates at STARVE_LIMIT.
REQ-022 SHALL, with RAM_ARB_FAIR_EN and counter == STARVE_LIMIT, grant if over ls for that one cycle (ls_gnt = 0); counter clears next cycle.
REQ-023 SHALL, without RAM_ARB_FAIR_EN, contain no counter and use pure ls priority (REQ-009).

Structure
REQ-024 SHALL take the owner encoding (NONE=2'd0, IF=2'd1, LS=2'd2) and the 32-bit address/data width constants from shared package riscv_mem_pkg.
REQ-025 SHALL place the starvation counter in sub-module arb_starve_cnt, instantiated only under RAM_ARB_FAIR_EN.

Verification
REQ-026 SHALL cover: if_req=1, if_addr=0x10, ls_req=0 -> if_gnt=1, ram_addr=0x10; next cycle if_rvalid=1, if_rdata=RAM[0x10].
REQ-027 SHALL cover: both req, ls_we=0, ls_addr=0x80 -> ls_gnt=1, if_gnt=0; next cycle ls_rvalid=1, if_rvalid=0.
REQ-028 SHALL cover: ls write ls_wstrb=4'b0011, ls_wdata=0xDEADBEEF at 0x40 -> ram_we=4'b0011, no ls_rvalid; later read of 0x40 returns low half 0xBEEF merged.
REQ-029 SHALL cover: IF granted at cycle N, if_flush=1 at N+1 -> if_rvalid=0 at N+1.
REQ-030 SHALL cover (RAM_ARB_FAIR_EN, STARVE_LIMIT=4): ls_req and if_req held high -> ls granted 4 cycles, if granted cycle 5, ls resumes cycle 6.
REQ-031 SHALL cover: rst_n=0 for one edge the cycle after an ls read grant -> ls_rvalid=0, all grants 0 during reset.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared memory-side constants and the response-owner encoding for the RAM arbiter.
package riscv_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles a fetch is denied by load/store; flags starvation at LIMIT.
// Saturating 3-bit counter, registered; the flag is valid in the same cycle as the count.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ls_req,
  input  logic if_gnt,
  output logic starved
);
  localparam logic [2:0] LIM = 3'(LIMIT);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= 3'd0;
    else if (!if_req || if_gnt)
      cnt <= 3'd0;
    else if (ls_req && cnt != LIM)
      cnt <= cnt + 3'd1;
  end

  assign starved = if_req && (cnt == LIM);
endmodule

// File: rtl/ram_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single-port RAM; grants are same-cycle, read data returns 1 cycle later, no back-pressure.
// Load/store wins by default; define RAM_ARB_FAIR_EN to force a fetch grant after STARVE_LIMIT denials.
module ram_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [STRB_W-1:0] ls_wstrb,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  owner_t owner, owner_nxt;
  logic   force_if;

`ifdef RAM_ARB_FAIR_EN
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .ls_req  (ls_req),
    .if_gnt  (if_gnt),
    .starved (force_if)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign force_if = 1'b0;
`endif

  // Grants are masked by reset so nothing reaches the RAM while rst_n is low.
  always_comb begin
    ls_gnt = 1'b0;
    if_gnt = 1'b0;
    if (rst_n) begin
      ls_gnt = ls_req && !force_if;
      if_gnt = if_req && !ls_gnt;
    end
  end

  always_comb begin
    ram_en    = if_gnt | ls_gnt;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = '0;
    if (ls_gnt) begin
      ram_addr  = ls_addr;
      ram_wdata = ls_wdata;
      if (ls_we)
        ram_we = ls_wstrb;
    end else if (if_gnt) begin
      ram_addr = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      owner <= OWN_NONE;
    else
      owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (ls_gnt && !ls_we)
      owner_nxt = OWN_LS;
    else if (if_gnt)
      owner_nxt = OWN_IF;
  end

  // rst_n gating drops a response whose grant preceded a reset edge.
  assign if_rvalid = rst_n && (owner == OWN_IF) && !if_flush;
  assign ls_rvalid = rst_n && (owner == OWN_LS);
  assign if_rdata  = ram_rdata;
  assign ls_rdata  = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus random stimulus for ram_arbiter, checked against a transaction-level model of the arbitration rules.
module tb_ram_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  int checks = 0;
  int errors = 0;

  // Model state: what response is owed next cycle and how long fetch has been starved.
  bit          pend_if, pend_ls;
  logic [31:0] pend_data;
  int          denied;

`ifdef RAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, read data one cycle after enable.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs against the model, then advance the model.
  task automatic step();
    bit          e_force, e_if, e_ls, e_ifv, e_lsv;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    #1;
    e_force = FAIR && rst_n && if_req && (denied == LIMIT);
    e_ls    = rst_n && ls_req && !e_force;
    e_if    = rst_n && if_req && !e_ls;
    e_addr  = e_ls ? ls_addr : (e_if ? if_addr : 32'h0);
    e_we    = (e_ls && ls_we) ? ls_wstrb : 4'h0;
    e_ifv   = rst_n && pend_if && !if_flush;
    e_lsv   = rst_n && pend_ls;
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
    chk("ls_gnt", {31'b0, ls_gnt}, {31'b0, e_ls});
    chk("ram_en", {31'b0, ram_en}, {31'b0, e_if | e_ls});
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_we", {28'b0, ram_we}, {28'b0, e_we});
    if (e_ls && ls_we) chk("ram_wdata", ram_wdata, ls_wdata);
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_ifv});
    chk("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, e_lsv});
    if (e_ifv) chk("if_rdata", if_rdata, pend_data);
    if (e_lsv) chk("ls_rdata", ls_rdata, pend_data);
    @(posedge clk);
    if (!rst_n) begin
      pend_if = 0; pend_ls = 0; denied = 0;
    end else begin
      pend_if   = e_if;
      pend_ls   = e_ls && !ls_we;
      pend_data = shadow[e_addr[9:2]];
      if (e_ls && ls_we)
        for (int b = 0; b < 4; b++)
          if (ls_wstrb[b]) shadow[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
      if (!if_req || e_if) denied = 0;
      else if (denied < LIMIT) denied++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 0; ls_req = 0; if_flush = 0; ls_we = 0;
    ls_wstrb = 4'h0; if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
  endtask

  initial begin
    logic [5:0]  pat, exp_pat;
    logic [31:0] orig40;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'(i) * 32'h9E3779B1;
      shadow[i] = 32'(i) * 32'h9E3779B1;
    end
    orig40 = shadow[16];
    pend_if = 0; pend_ls = 0; pend_data = 0; denied = 0;

    // Reset with both requests high: all grants must stay low.
    idle(); rst_n = 0; if_req = 1; ls_req = 1; ls_we = 1; ls_wstrb = 4'hF;
    step(); step();
    rst_n = 1; idle();
    step();

    // Lone fetch at 0x10, data next cycle.
    if_req = 1; if_addr = 32'h10;
    step();
    idle();
    chk("fetch_rvalid", {31'b0, if_rvalid}, 32'h1);
    chk("fetch_rdata", if_rdata, shadow[4]);
    step();

    // Both request, ls read at 0x80 wins.
    if_req = 1; if_addr = 32'h20; ls_req = 1; ls_addr = 32'h80;
    step();
    idle();
    step();

    // Partial-strobe write then read-back.
    ls_req = 1; ls_we = 1; ls_wstrb = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF;
    step();
    idle(); ls_req = 1; ls_addr = 32'h40;
    step();
    idle();
    chk("merge_data", ls_rdata, {orig40[31:16], 16'hBEEF});
    step();

    // Flush kills the older response; a fetch granted alongside the flush still returns.
    if_req = 1; if_addr = 32'h100;
    step();
    if_flush = 1; if_addr = 32'h104;
    step();
    idle();
    chk("post_flush_rdata", if_rdata, shadow[65]);
    step();

    // Reset the cycle after an ls read grant drops its response.
    ls_req = 1; ls_addr = 32'h84;
    step();
    idle(); rst_n = 0; if_req = 1; ls_req = 1;
    step();
    rst_n = 1; idle();
    step();

    // Both requests held high: fairness pattern.
    if_req = 1; ls_req = 1; if_addr = 32'h8; ls_addr = 32'hC;
    for (int c = 0; c < 6; c++) begin
      #1 pat[c] = ls_gnt;
      step();
    end
    exp_pat = FAIR ? 6'b101111 : 6'b111111;
    chk("fair_pattern", {26'b0, pat}, {26'b0, exp_pat});
    idle();
    step();

    // Randomized traffic with occasional resets and flushes.
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      if_req   = ($urandom_range(0, 2) != 0);
      ls_req   = ($urandom_range(0, 1) != 0);
      ls_we    = ($urandom_range(0, 2) == 0);
      ls_wstrb = 4'($urandom_range(0, 15));
      if_flush = ($urandom_range(0, 5) == 0);
      if_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      ls_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      ls_wdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
